inst_encoder: RTL and testbench

RV32I instruction encoder and program writer: the inverse of the core's immediate decoder. Accepts field-level instruction requests (format, opcode, registers, functs, 32-bit immediate) over a valid/ready stream. Packs each request into a 32-bit instruction word, range-checking the immediate, and writes the words to sequential instruction-memory addresses through a valid/ready write port. Used by the loader/self-test path to build programs in IMEM before the SCPU is released from reset.

---
 rtl/inst_enc_pkg.sv | 29 ++
 rtl/inst_pack.sv | 77 +++++++
 rtl/inst_encoder.sv | 197 +++++++++++++++++++
 tb/tb_inst_encoder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_enc_pkg.sv
// ----------------------------------------------------------------------------
// inst_enc_pkg
//   Shared definitions for the RV32I instruction encoder / program writer.
//   - fmt_e   : instruction format selector carried on in_fmt (6 and 7 are
//               not members and are treated as illegal by the packer)
//   - NOP     : encoding substituted for any illegal request (addi x0,x0,0)
//   - state_e : load-sequencer FSM states
// ----------------------------------------------------------------------------
package inst_enc_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/inst_pack.sv
// ----------------------------------------------------------------------------
// inst_pack
//   Purely combinational RV32I field packer. Scatters the immediate into the
//   bit positions of the selected format and flags whether the request is
//   representable in that format.
//   Ports:
//     fmt            in   format selector (fmt_e encoding; 6/7 illegal)
//     opcode         in   7-bit opcode
//     rd, rs1, rs2   in   register fields
//     funct3, funct7 in   function fields
//     imm            in   full 32-bit immediate (byte value)
//     word           out  packed instruction (NOP when the format is illegal)
//     legal          out  1 when the immediate fits and the format is valid
// ----------------------------------------------------------------------------
module inst_pack
    import inst_enc_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        legal
);

    // Sign-extension checks: the upper immediate bits must all be copies of
    // the highest bit that the format can actually carry.
    logic ext_11;
    logic ext_12;
    logic ext_20;

    assign ext_11 = (imm[31:11] == '0) || (imm[31:11] == '1);
    assign ext_12 = (imm[31:12] == '0) || (imm[31:12] == '1);
    assign ext_20 = (imm[31:20] == '0) || (imm[31:20] == '1);

    always_comb begin
        word  = NOP;
        legal = 1'b0;
        case (fmt)
            FMT_R: begin
                word  = {funct7, rs2, rs1, funct3, rd, opcode};
                legal = 1'b1;
            end
            FMT_I: begin
                word  = {imm[11:0], rs1, funct3, rd, opcode};
                legal = ext_11;
            end
            FMT_S: begin
                word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                legal = ext_11;
            end
            FMT_B: begin
                // Branch offsets are halfword aligned; bit 0 is implicit.
                word  = {imm[12], imm[10:5], rs2, rs1, funct3,
                         imm[4:1], imm[11], opcode};
                legal = ext_12 && !imm[0];
            end
            FMT_U: begin
                word  = {imm[31:12], rd, opcode};
                legal = (imm[11:0] == '0);
            end
            FMT_J: begin
                word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                legal = ext_20 && !imm[0];
            end
            default: begin
                word  = NOP;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// ----------------------------------------------------------------------------
// inst_encoder
//   Accepts field-level RV32I instruction requests, encodes them and writes
//   the words to consecutive IMEM word addresses starting at BASE_ADDR.
//
//   Handshakes: both the request port (in_valid/in_ready) and the memory
//   write port (mem_valid/mem_ready) transfer exactly on a cycle where valid
//   and ready are both high at the rising clock edge. Once raised, mem_valid
//   and its mem_addr/mem_data stay unchanged until that transfer happens.
//   in_ready does not depend on in_valid.
//
//   Ports:
//     clk, rst          clock, asynchronous active-high reset
//     start             begin a program load (only honoured while idle)
//     in_*              request stream (format, fields, immediate, last flag)
//     mem_valid/ready   write port handshake; mem_addr/mem_data payload
//     busy              loading or draining
//     done              one-cycle pulse when the final word has been written
//     err, err_addr     sticky illegal-request flag and first offending address
//     ovf               sticky: address counter wrapped past its maximum
//     count             words written since start (saturating)
//     dbg_state         current FSM state (state_e encoding)
// ----------------------------------------------------------------------------
module inst_encoder
    import inst_enc_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr,
    output logic              ovf,
    output logic [ADDR_W:0]   count,
    output logic [1:0]        dbg_state
);

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   CNT_MAX  = '1;

    state_e            state;
    state_e            state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_inc;
    logic [ADDR_W-1:0] word_addr;
    logic [ADDR_W:0]   count_r;
    logic              err_r;
    logic [ADDR_W-1:0] err_addr_r;
    logic              ovf_r;
    logic              mem_valid_r;
    logic [31:0]       mem_data_r;
    logic [31:0]       packed_word;
    logic              packed_legal;
    logic              accept;
    logic              wr_done;
    logic              load_start;

    inst_pack u_pack (
        .fmt    (in_fmt),
        .opcode (in_opcode),
        .rd     (in_rd),
        .rs1    (in_rs1),
        .rs2    (in_rs2),
        .funct3 (in_funct3),
        .funct7 (in_funct7),
        .imm    (in_imm),
        .word   (packed_word),
        .legal  (packed_legal)
    );

    assign accept     = in_valid && in_ready;
    assign wr_done    = mem_valid_r && mem_ready;
    assign load_start = (state == ST_IDLE) && start;
    assign addr_inc   = addr + ADDR_ONE;

    // Only one word is ever in flight, so 'addr' is always the address of
    // the pending word. A word accepted in the same cycle the pending one
    // retires lands on the following address.
    assign word_addr  = wr_done ? addr_inc : addr;

    // ------------------------------------------------------------------------
    // FSM: next state and state-decoded outputs
    // ------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                busy     = 1'b1;
                in_ready = !mem_valid_r || mem_ready;
                if (in_valid && in_ready && in_last) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (!mem_valid_r) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // ------------------------------------------------------------------------
    // Output register: loads on accept, empties when the write retires.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_valid_r <= 1'b0;
            mem_data_r  <= '0;
        end else if (accept) begin
            mem_valid_r <= 1'b1;
            mem_data_r  <= packed_legal ? packed_word : NOP;
        end else if (wr_done) begin
            mem_valid_r <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Address, count and overflow. Cleared on a honoured start; mem_valid is
    // always low in IDLE, so no write can retire in the same cycle.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr    <= BASE;
            count_r <= '0;
            ovf_r   <= 1'b0;
        end else if (load_start) begin
            addr    <= BASE;
            count_r <= '0;
            ovf_r   <= 1'b0;
        end else if (wr_done) begin
            addr <= addr_inc;
            if (count_r != CNT_MAX) count_r <= count_r + CNT_ONE;
            if (addr == ADDR_MAX)   ovf_r   <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Sticky error flag; err_addr keeps the first offending address only.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r      <= 1'b0;
            err_addr_r <= '0;
        end else if (load_start) begin
            err_r      <= 1'b0;
            err_addr_r <= '0;
        end else if (accept && !packed_legal && !err_r) begin
            err_r      <= 1'b1;
            err_addr_r <= word_addr;
        end
    end

    assign mem_valid = mem_valid_r;
    assign mem_addr  = addr;
    assign mem_data  = mem_data_r;
    assign err       = err_r;
    assign err_addr  = err_addr_r;
    assign ovf       = ovf_r;
    assign count     = count_r;
    assign dbg_state = state;

endmodule

// File: tb/tb_inst_encoder.sv
// ----------------------------------------------------------------------------
// tb_inst_encoder
//   Directed vectors with hand-computed encodings. Two instances share the
//   request bus and mem_ready: dut1 (ADDR_W=10) carries most programs, dut2
//   (ADDR_W=2) exercises address wrap. Each is started separately, so only
//   one instance is ever in LOAD. Accepted requests push {addr,data} into a
//   per-instance expected queue; monitors pop and compare on every write.
// ----------------------------------------------------------------------------
module tb_inst_encoder;
  import inst_enc_pkg::*;

  localparam int AW  = 10;
  localparam int AW2 = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic        start1 = 1'b0;
  logic        start2 = 1'b0;
  logic        in_valid = 1'b0;
  logic [2:0]  in_fmt = '0;
  logic [6:0]  in_opcode = '0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [31:0] in_imm = '0;
  logic        in_last = 1'b0;
  logic        mem_ready = 1'b1;

  // ---------------- dut1 outputs ----------------
  logic          rdy1, mv1, busy1, done1, err1, ovf1;
  logic [AW-1:0] ma1, ea1;
  logic [31:0]   md1;
  logic [AW:0]   cnt1;
  logic [1:0]    st1;

  // ---------------- dut2 outputs ----------------
  logic           rdy2, mv2, busy2, done2, err2, ovf2;
  logic [AW2-1:0] ma2, ea2;
  logic [31:0]    md2;
  logic [AW2:0]   cnt2;
  logic [1:0]     st2;

  inst_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .in_valid(in_valid), .in_ready(rdy1), .in_fmt(in_fmt), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .in_imm(in_imm), .in_last(in_last),
    .mem_valid(mv1), .mem_ready(mem_ready), .mem_addr(ma1), .mem_data(md1),
    .busy(busy1), .done(done1), .err(err1), .err_addr(ea1), .ovf(ovf1),
    .count(cnt1), .dbg_state(st1)
  );

  inst_encoder #(.ADDR_W(AW2), .BASE_ADDR(0)) dut2 (
    .clk(clk), .rst(rst), .start(start2),
    .in_valid(in_valid), .in_ready(rdy2), .in_fmt(in_fmt), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .in_imm(in_imm), .in_last(in_last),
    .mem_valid(mv2), .mem_ready(mem_ready), .mem_addr(ma2), .mem_data(md2),
    .busy(busy2), .done(done2), .err(err2), .err_addr(ea2), .ovf(ovf2),
    .count(cnt2), .dbg_state(st2)
  );

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_fail = 0;
  logic [AW+31:0]  exp_q[$];
  logic [AW2+31:0] exp2_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && mv1 && mem_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL wr1_unexpected: got addr %h data %h, expected no write", ma1, md1);
      end else begin
        logic [AW+31:0] e;
        e = exp_q.pop_front();
        check("wr1", 64'({ma1, md1}), 64'(e));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && mv2 && mem_ready) begin
      if (exp2_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL wr2_unexpected: got addr %h data %h, expected no write", ma2, md2);
      end else begin
        logic [AW2+31:0] e;
        e = exp2_q.pop_front();
        check("wr2", 64'({ma2, md2}), 64'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All drivers change inputs 2 time units after a rising edge.
  task automatic do_start(input bit sel);
    if (sel) start2 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #2;
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic send(input bit sel, input logic [2:0] fmt, input logic [6:0] op,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                      input logic last, input logic [31:0] exp_word, input int exp_addr);
    bit acc;
    acc = 1'b0;
    in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_last = last;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = sel ? rdy2 : rdy1;
      if (acc) begin
        if (sel) exp2_q.push_back({exp_addr[AW2-1:0], exp_word});
        else     exp_q.push_back({exp_addr[AW-1:0], exp_word});
      end
      @(posedge clk); #2;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!acc) begin
      n_vec++;
      n_fail++;
      $display("FAIL accept_timeout: got no in_ready, expected accept of word for addr %0d", exp_addr);
    end
  endtask

  // Returns at the falling edge where done is seen (or after the budget).
  task automatic wait_done(input bit sel, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = sel ? done2 : done1;
    end
    check(name, 64'(seen), 64'(1));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    // Reset state, sampled while reset is held.
    #12;
    check("rst_in_ready",  64'(rdy1), 64'(0));
    check("rst_mem_valid", 64'(mv1),  64'(0));
    check("rst_mem_addr",  64'(ma1),  64'(0));
    check("rst_mem_data",  64'(md1),  64'(0));
    check("rst_flags",     64'({busy1, done1, err1, ovf1}), 64'(0));
    check("rst_err_addr",  64'(ea1),  64'(0));
    check("rst_count",     64'(cnt1), 64'(0));
    check("rst_state",     64'(st1),  64'(ST_IDLE));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #2;

    // ---- P1: single I-type, immediate -1, one-cycle latency ----
    do_start(0);
    check("p1_busy", 64'(busy1), 64'(1));
    send(0, FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 1'b1, 32'hFFF0_0093, 0);
    check("p1_latency", 64'({mv1, ma1, md1}), 64'({1'b1, 10'd0, 32'hFFF0_0093}));
    wait_done(0, "p1_done");
    check("p1_count", 64'(cnt1), 64'(1));
    check("p1_err",   64'(err1), 64'(0));
    @(negedge clk);
    check("p1_done_pulse", 64'(done1), 64'(0));
    @(posedge clk); #2;

    // ---- P2: mixed formats, illegal requests, start ignored mid-load ----
    do_start(0);
    send(0, FMT_B, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFF8, 1'b0, 32'hFE20_8CE3, 0);
    send(0, FMT_J, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 1'b0, 32'h0010_00EF, 1);
    send(0, FMT_R, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0,         1'b0, 32'h0020_81B3, 2);
    send(0, FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 1'b0, 32'h0000_0013, 3);
    send(0, FMT_S, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'h0000_0008, 1'b0, 32'h0020_A423, 4);
    do_start(0);
    send(0, FMT_U, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 1'b0, 32'h1234_52B7, 5);
    send(0, FMT_U, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001, 1'b0, 32'h0000_0013, 6);
    send(0, 3'd6,  7'h33, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'h0,         1'b0, 32'h0000_0013, 7);
    send(0, FMT_B, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0000_0005, 1'b0, 32'h0000_0013, 8);
    send(0, FMT_J, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 1'b1, 32'hFFDF_F06F, 9);
    wait_done(0, "p2_done");
    check("p2_err",      64'(err1), 64'(1));
    check("p2_err_addr", 64'(ea1),  64'(3));
    check("p2_count",    64'(cnt1), 64'(10));
    check("p2_ovf",      64'(ovf1), 64'(0));
    @(posedge clk); #2;

    // ---- P3: 3-cycle mem_ready stall mid-stream ----
    do_start(0);
    check("p3_err_cleared", 64'(err1), 64'(0));
    send(0, FMT_R, 7'h33, 5'd1, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0, 1'b0, 32'h0020_80B3, 0);
    send(0, FMT_R, 7'h33, 5'd2, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0, 1'b0, 32'h0020_8133, 1);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("p3_stall_hold", 64'({mv1, ma1, md1}), 64'({1'b1, exp_q[0]}));
      check("p3_stall_rdy",  64'(rdy1), 64'(0));
    end
    @(posedge clk); #2;
    mem_ready = 1'b1;
    send(0, FMT_R, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0, 1'b0, 32'h0020_81B3, 2);
    send(0, FMT_R, 7'h33, 5'd4, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0, 1'b0, 32'h0020_8233, 3);
    send(0, FMT_R, 7'h33, 5'd5, 5'd1, 5'd2, 3'd0, 7'h20, 32'h0, 1'b1, 32'h4020_82B3, 4);
    wait_done(0, "p3_done");
    check("p3_count", 64'(cnt1), 64'(5));
    @(posedge clk); #2;

    // ---- P4: ADDR_W=2 instance wraps on the 5th word ----
    do_start(1);
    send(1, FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0, 32'h0010_0093, 0);
    send(1, FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 1'b0, 32'h0020_0093, 1);
    send(1, FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 1'b0, 32'h0030_0093, 2);
    send(1, FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4, 1'b0, 32'h0040_0093, 3);
    send(1, FMT_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1, 32'h0050_0093, 0);
    wait_done(1, "p4_done");
    check("p4_ovf",   64'(ovf2), 64'(1));
    check("p4_count", 64'(cnt2), 64'(5));
    @(posedge clk); #2;

    // ---- P5: reset while a write is pending ----
    do_start(0);
    mem_ready = 1'b0;
    send(0, FMT_I, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7, 1'b0, 32'h0070_0113, 0);
    check("p5_pending", 64'(mv1), 64'(1));
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("p5_rst_outputs", 64'({rdy1, mv1, busy1, done1, err1, ovf1}), 64'(0));
    check("p5_rst_addr",    64'({ma1, ea1}), 64'(0));
    check("p5_rst_data",    64'(md1),  64'(0));
    check("p5_rst_count",   64'(cnt1), 64'(0));
    check("p5_rst_state",   64'(st1),  64'(ST_IDLE));
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);

    check("sb1_empty", 64'(exp_q.size()),  64'(0));
    check("sb2_empty", 64'(exp2_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
